// File: rtl/npu_sram_pkg.sv
// npu_sram_pkg: shared types and constants for the dual-port NPU SRAM
package npu_sram_pkg;
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_e;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;
  localparam int COLL_W = 16;
endpackage

// File: rtl/npu_sram_dp_array.sv
// npu_sram_dp_array: true dual-port byte-enabled RAM with one registered read stage
module npu_sram_dp_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic                clk,
  input  logic                a_we,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic [DATA_W-1:0]   a_rdata,
  input  logic                b_we,
  input  logic [DATA_W/8-1:0] b_be,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic [DATA_W-1:0]   b_rdata
);
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  // byte-lane writes on both ports (port a applied last) and read-before-write outputs
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_W/8; i++) begin
      if (b_we && b_be[i]) mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
      if (a_we && a_be[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
    end
    a_rdata <= mem[a_addr];
    b_rdata <= mem[b_addr];
  end
endmodule

// File: rtl/npu_sram_dp.sv
// npu_sram_dp: dual-port Avalon-MM SRAM with zero-fill, forwarding and collision counting
module npu_sram_dp
  import npu_sram_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 12,
  parameter int RD_LAT    = 1,
  parameter int INIT_ZERO = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic                s1_waitrequest,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [DATA_W-1:0]   s2_writedata,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid,
  output logic                s2_waitrequest,
  output logic                busy,
  output logic [COLL_W-1:0]   collision_count
);
  localparam int NB = DATA_W/8;
  state_e state, state_nx;
  logic init_done, coll;
  logic [ADDR_W-1:0] fill_cnt;
  logic [ADDR_W-1:0] addr [2];
  logic [NB-1:0] be [2];
  logic [DATA_W-1:0] wdata [2], ram_q [2];
  logic [1:0] cs, rd, wr, acc_rd, acc_wr, we;
  assign cs = {s2_chipselect, s1_chipselect};
  assign rd = {s2_read, s1_read};
  assign wr = {s2_write, s1_write};
  assign addr[0] = s1_address;
  assign addr[1] = s2_address;
  assign be[0] = s1_byteenable;
  assign be[1] = s2_byteenable;
  assign wdata[0] = s1_writedata;
  assign wdata[1] = s2_writedata;
  assign acc_wr = cs & wr & ~{2{busy}};
  assign acc_rd = cs & rd & ~wr & ~{2{busy}};
  assign coll = &acc_wr && addr[0] == addr[1];
  assign we = {acc_wr[1] & ~coll, acc_wr[0]};
  // state register; init_done marks that the post-reset auto-fill decision was taken
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      init_done <= 1'b0;
    end else begin
      state <= state_nx;
      init_done <= 1'b1;
    end
  // next state: start fill on clear or first edge after reset, leave after last word unless restarted
  always_comb
    state_nx = state == IDLE ? ((clear || (INIT_ZERO != 0 && !init_done)) ? CLEAR : IDLE)
                             : ((!clear && fill_cnt == '1) ? IDLE : CLEAR);
  // outputs: both ports stall while the fill owns the array
  always_comb begin
    busy = state == CLEAR;
    s1_waitrequest = state == CLEAR;
    s2_waitrequest = state == CLEAR;
  end
  // fill address walks up during CLEAR and restarts at zero on a clear pulse
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) fill_cnt <= '0;
    else fill_cnt <= (state == CLEAR && !clear) ? fill_cnt + 1'b1 : '0;
  // saturating count of dropped s2 writes
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) collision_count <= '0;
    else if (coll && collision_count != '1) collision_count <= collision_count + 1'b1;
  npu_sram_dp_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
    .clk     (clk),
    .a_we    (busy | we[0]),
    .a_be    (busy ? {NB{1'b1}} : be[0]),
    .a_addr  (busy ? fill_cnt : addr[0]),
    .a_wdata (busy ? {DATA_W{1'b0}} : wdata[0]),
    .a_rdata (ram_q[0]),
    .b_we    (we[1]),
    .b_be    (be[1]),
    .b_addr  (addr[1]),
    .b_wdata (wdata[1]),
    .b_rdata (ram_q[1])
  );
  for (genvar p = 0; p < 2; p++) begin : g_port
    localparam int OTH = 1 - p;
    logic fwd, v1, v2;
    logic [NB-1:0] fwd_be;
    logic [DATA_W-1:0] fwd_d, merged, rd_q, rdata;
    logic rvalid;
    // valid pipeline, forwarding capture from the other port, and held output word
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        fwd <= 1'b0;
        fwd_be <= '0;
        fwd_d <= '0;
        v1 <= 1'b0;
        v2 <= 1'b0;
        rd_q <= '0;
      end else begin
        v1 <= acc_rd[p];
        v2 <= v1;
        if (acc_rd[p]) begin
          fwd <= we[OTH] && addr[OTH] == addr[p];
          fwd_be <= be[OTH];
          fwd_d <= wdata[OTH];
        end
        if (v1) rd_q <= merged;
      end
    // merge same-cycle write lanes from the other port over the old word
    always_comb begin
      merged = ram_q[p];
      for (int i = 0; i < NB; i++)
        if (fwd && fwd_be[i]) merged[i*8 +: 8] = fwd_d[i*8 +: 8];
    end
    assign rdata = (RD_LAT == RD_LAT_MIN && v1) ? merged : rd_q;
    assign rvalid = RD_LAT == RD_LAT_MIN ? v1 : v2;
  end
  assign s1_readdata = g_port[0].rdata;
  assign s1_readdatavalid = g_port[0].rvalid;
  assign s2_readdata = g_port[1].rdata;
  assign s2_readdatavalid = g_port[1].rvalid;
endmodule

// File: tb/tb_npu_sram_dp.sv
// tb_npu_sram_dp: directed checks of the dual-port SRAM at RD_LAT=1 and RD_LAT=2
module tb_npu_sram_dp;
  logic clk = 1'b0, reset_n = 1'b0, clear = 1'b0;
  logic [3:0] s1_address = '0, s2_address = '0;
  logic [1:0] s1_byteenable = '0, s2_byteenable = '0;
  logic s1_chipselect = 1'b0, s1_read = 1'b0, s1_write = 1'b0;
  logic s2_chipselect = 1'b0, s2_read = 1'b0, s2_write = 1'b0;
  logic [15:0] s1_writedata = '0, s2_writedata = '0;
  logic [15:0] s1_rdata [2], s2_rdata [2], coll_cnt [2];
  logic [1:0] s1_rvalid, s2_rvalid, s1_wait, s2_wait, busy;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    npu_sram_dp #(.DATA_W(16), .ADDR_W(4), .RD_LAT(k + 1), .INIT_ZERO(1)) dut (
      .clk(clk), .reset_n(reset_n), .clear(clear),
      .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
      .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
      .s1_readdata(s1_rdata[k]), .s1_readdatavalid(s1_rvalid[k]), .s1_waitrequest(s1_wait[k]),
      .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
      .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
      .s2_readdata(s2_rdata[k]), .s2_readdatavalid(s2_rvalid[k]), .s2_waitrequest(s2_wait[k]),
      .busy(busy[k]), .collision_count(coll_cnt[k])
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ports();
    s1_chipselect = 0; s1_read = 0; s1_write = 0;
    s2_chipselect = 0; s2_read = 0; s2_write = 0;
  endtask

  // gather the first return on a port after the acceptance edge, with latency and pulse count
  task automatic collect(input int port, output logic [1:0][15:0] d, output logic [1:0][3:0] lat,
                         output logic [1:0][3:0] np);
    d = '0; lat = '0; np = '0;
    for (int c = 1; c <= 4; c++) begin
      for (int k = 0; k < 2; k++)
        if (port == 1 ? s1_rvalid[k] : s2_rvalid[k]) begin
          if (np[k] == 0) begin
            lat[k] = c[3:0];
            d[k] = port == 1 ? s1_rdata[k] : s2_rdata[k];
          end
          np[k] = np[k] + 1'b1;
        end
      step();
    end
  endtask

  task automatic do_read(input int port, input logic [3:0] a, output logic [1:0][15:0] d,
                         output logic [1:0][3:0] lat, output logic [1:0][3:0] np);
    if (port == 1) begin s1_chipselect = 1; s1_read = 1; s1_address = a; end
    else begin s2_chipselect = 1; s2_read = 1; s2_address = a; end
    step();
    idle_ports();
    collect(port, d, lat, np);
  endtask

  task automatic do_write(input int port, input logic [3:0] a, input logic [15:0] wd, input logic [1:0] be);
    if (port == 1) begin s1_chipselect = 1; s1_write = 1; s1_address = a; s1_writedata = wd; s1_byteenable = be; end
    else begin s2_chipselect = 1; s2_write = 1; s2_address = a; s2_writedata = wd; s2_byteenable = be; end
    step();
    idle_ports();
  endtask

  task automatic test_reset();
    step(); step();
    for (int k = 0; k < 2; k++) begin
      checks++; if (busy[k] !== 1'b0) begin errors++; $display("FAIL rst_busy dut%0d: got %b expected 0", k, busy[k]); end
      checks++; if ({s1_wait[k], s2_wait[k]} !== 2'b00) begin errors++; $display("FAIL rst_wait dut%0d: got %b expected 00", k, {s1_wait[k], s2_wait[k]}); end
      checks++; if ({s1_rvalid[k], s2_rvalid[k]} !== 2'b00) begin errors++; $display("FAIL rst_valid dut%0d: got %b expected 00", k, {s1_rvalid[k], s2_rvalid[k]}); end
      checks++; if ({s1_rdata[k], s2_rdata[k]} !== 32'h0) begin errors++; $display("FAIL rst_rdata dut%0d: got %h expected 0", k, {s1_rdata[k], s2_rdata[k]}); end
      checks++; if (coll_cnt[k] !== 16'h0) begin errors++; $display("FAIL rst_coll dut%0d: got %h expected 0", k, coll_cnt[k]); end
    end
  endtask

  task automatic test_init_fill();
    int bc [2];
    logic [1:0] wbad;
    logic [1:0][15:0] d;
    logic [1:0][3:0] lat, np;
    bc = '{0, 0}; wbad = '0;
    reset_n = 1;
    for (int c = 0; c < 40; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        if (busy[k]) bc[k]++;
        if ({s1_wait[k], s2_wait[k]} !== {2{busy[k]}}) wbad[k] = 1'b1;
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++; if (bc[k] != 16) begin errors++; $display("FAIL fill_busy_cycles dut%0d: got %0d expected 16", k, bc[k]); end
      checks++; if (wbad[k] !== 1'b0) begin errors++; $display("FAIL fill_waitrequest dut%0d: got mismatch=%b expected 0", k, wbad[k]); end
    end
    for (int a = 0; a < 16; a++) begin
      do_read((a % 2) + 1, a[3:0], d, lat, np);
      for (int k = 0; k < 2; k++) begin
        checks++; if (d[k] !== 16'h0 || lat[k] == 0) begin errors++; $display("FAIL fill_zero a%0d dut%0d: got %h lat %0d expected 0000", a, k, d[k], lat[k]); end
      end
    end
  endtask

  task automatic test_byteenable();
    logic [1:0][15:0] d;
    logic [1:0][3:0] lat, np;
    do_write(1, 4'd3, 16'hA5A5, 2'b11);
    do_write(1, 4'd3, 16'h00FF, 2'b01);
    do_read(2, 4'd3, d, lat, np);
    for (int k = 0; k < 2; k++) begin
      checks++; if (d[k] !== 16'hA5FF) begin errors++; $display("FAIL be_data dut%0d: got %h expected A5FF", k, d[k]); end
      checks++; if (lat[k] != 4'(k + 1)) begin errors++; $display("FAIL be_latency dut%0d: got %0d expected %0d", k, lat[k], k + 1); end
      checks++; if (np[k] != 4'd1) begin errors++; $display("FAIL be_pulses dut%0d: got %0d expected 1", k, np[k]); end
    end
  endtask

  task automatic test_forward();
    logic [1:0][15:0] d;
    logic [1:0][3:0] lat, np;
    s1_chipselect = 1; s1_write = 1; s1_address = 4'd9; s1_writedata = 16'hBEEF; s1_byteenable = 2'b11;
    s2_chipselect = 1; s2_read = 1; s2_address = 4'd9;
    step();
    idle_ports();
    collect(2, d, lat, np);
    for (int k = 0; k < 2; k++) begin
      checks++; if (d[k] !== 16'hBEEF || lat[k] != 4'(k + 1)) begin errors++; $display("FAIL fwd_full dut%0d: got %h lat %0d expected BEEF lat %0d", k, d[k], lat[k], k + 1); end
    end
    s2_chipselect = 1; s2_write = 1; s2_address = 4'd9; s2_writedata = 16'h1234; s2_byteenable = 2'b10;
    s1_chipselect = 1; s1_read = 1; s1_address = 4'd9;
    step();
    idle_ports();
    collect(1, d, lat, np);
    for (int k = 0; k < 2; k++) begin
      checks++; if (d[k] !== 16'h12EF) begin errors++; $display("FAIL fwd_merge dut%0d: got %h expected 12EF", k, d[k]); end
    end
    do_read(2, 4'd9, d, lat, np);
    for (int k = 0; k < 2; k++) begin
      checks++; if (d[k] !== 16'h12EF) begin errors++; $display("FAIL fwd_stored dut%0d: got %h expected 12EF", k, d[k]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [4] = '{16'h1357, 16'h2468, 16'h9ABC, 16'hDEF0};
    logic [15:0] q1 [2][4], q2 [2][4];
    int n1 [2], n2 [2];
    logic [1:0] stall;
    stall = '0; n1 = '{0, 0}; n2 = '{0, 0};
    for (int a = 0; a < 4; a += 2) begin
      s1_chipselect = 1; s1_write = 1; s1_address = a[3:0]; s1_writedata = vals[a]; s1_byteenable = 2'b11;
      s2_chipselect = 1; s2_write = 1; s2_address = 4'(a + 1); s2_writedata = vals[a + 1]; s2_byteenable = 2'b11;
      for (int k = 0; k < 2; k++) if (s1_wait[k] || s2_wait[k]) stall[k] = 1'b1;
      step();
    end
    idle_ports();
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        s2_chipselect = 1; s2_read = 1; s2_address = c[3:0];
        s1_chipselect = 1; s1_read = 1; s1_address = 4'(3 - c);
      end else idle_ports();
      step();
      for (int k = 0; k < 2; k++) begin
        if (s2_rvalid[k]) begin if (n2[k] < 4) q2[k][n2[k]] = s2_rdata[k]; n2[k]++; end
        if (s1_rvalid[k]) begin if (n1[k] < 4) q1[k][n1[k]] = s1_rdata[k]; n1[k]++; end
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++; if (stall[k] !== 1'b0) begin errors++; $display("FAIL b2b_no_stall dut%0d: got %b expected 0", k, stall[k]); end
      checks++; if (coll_cnt[k] !== 16'h0) begin errors++; $display("FAIL b2b_no_coll dut%0d: got %h expected 0", k, coll_cnt[k]); end
      checks++; if (n1[k] != 4 || n2[k] != 4) begin errors++; $display("FAIL b2b_count dut%0d: got %0d/%0d expected 4/4", k, n1[k], n2[k]); end
      for (int i = 0; i < 4; i++) begin
        if (i < n2[k]) begin
          checks++; if (q2[k][i] !== vals[i]) begin errors++; $display("FAIL b2b_s2_%0d dut%0d: got %h expected %h", i, k, q2[k][i], vals[i]); end
        end
        if (i < n1[k]) begin
          checks++; if (q1[k][i] !== vals[3 - i]) begin errors++; $display("FAIL b2b_s1_%0d dut%0d: got %h expected %h", i, k, q1[k][i], vals[3 - i]); end
        end
      end
    end
  endtask

  task automatic test_collision();
    logic [1:0][15:0] d;
    logic [1:0][3:0] lat, np;
    s1_chipselect = 1; s1_write = 1; s1_address = 4'd7; s1_writedata = 16'h1111; s1_byteenable = 2'b11;
    s2_chipselect = 1; s2_write = 1; s2_address = 4'd7; s2_writedata = 16'h2222; s2_byteenable = 2'b11;
    step();
    idle_ports();
    for (int k = 0; k < 2; k++) begin
      checks++; if (coll_cnt[k] !== 16'h1) begin errors++; $display("FAIL coll_one dut%0d: got %h expected 0001", k, coll_cnt[k]); end
    end
    do_read(2, 4'd7, d, lat, np);
    for (int k = 0; k < 2; k++) begin
      checks++; if (d[k] !== 16'h1111) begin errors++; $display("FAIL coll_data dut%0d: got %h expected 1111", k, d[k]); end
    end
    s1_chipselect = 1; s1_write = 1; s2_chipselect = 1; s2_write = 1;
    for (int i = 0; i < 65536; i++) step();
    idle_ports();
    step();
    for (int k = 0; k < 2; k++) begin
      checks++; if (coll_cnt[k] !== 16'hFFFF) begin errors++; $display("FAIL coll_sat dut%0d: got %h expected FFFF", k, coll_cnt[k]); end
    end
  endtask

  task automatic test_clear_restart();
    int bc [2];
    logic [1:0][15:0] d;
    logic [1:0][3:0] lat, np;
    bc = '{0, 0};
    do_write(1, 4'd5, 16'h5555, 2'b11);
    clear = 1;
    step();
    clear = 0;
    for (int i = 1; i <= 40; i++) begin
      for (int k = 0; k < 2; k++) if (busy[k]) bc[k]++;
      clear = i == 5;
      step();
    end
    clear = 0;
    for (int k = 0; k < 2; k++) begin
      checks++; if (bc[k] != 21) begin errors++; $display("FAIL clr_restart_cycles dut%0d: got %0d expected 21", k, bc[k]); end
    end
    do_read(1, 4'd5, d, lat, np);
    for (int k = 0; k < 2; k++) begin
      checks++; if (d[k] !== 16'h0 || lat[k] == 0) begin errors++; $display("FAIL clr_zeroed dut%0d: got %h expected 0000", k, d[k]); end
    end
  endtask

  task automatic test_reset_abort();
    do_write(1, 4'd3, 16'hCAFE, 2'b11);
    s1_chipselect = 1; s1_read = 1; s1_address = 4'd3;
    step();
    idle_ports();
    checks++; if (s1_rvalid[0] !== 1'b1 || s1_rdata[0] !== 16'hCAFE) begin errors++; $display("FAIL abort_pre_valid dut0: got %b/%h expected 1/CAFE", s1_rvalid[0], s1_rdata[0]); end
    reset_n = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (s1_rvalid[k] !== 1'b0 || s1_rdata[k] !== 16'h0) begin errors++; $display("FAIL abort_read_flush dut%0d: got %b/%h expected 0/0000", k, s1_rvalid[k], s1_rdata[k]); end
    end
    step();
    reset_n = 1;
    step(); step(); step();
    for (int k = 0; k < 2; k++) begin
      checks++; if (busy[k] !== 1'b1) begin errors++; $display("FAIL abort_pre_busy dut%0d: got %b expected 1", k, busy[k]); end
    end
    reset_n = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (busy[k] !== 1'b0 || {s1_wait[k], s2_wait[k]} !== 2'b00) begin errors++; $display("FAIL abort_fill dut%0d: got busy %b wait %b expected 0 00", k, busy[k], {s1_wait[k], s2_wait[k]}); end
      checks++; if ({s1_rvalid[k], s2_rvalid[k]} !== 2'b00) begin errors++; $display("FAIL abort_valid dut%0d: got %b expected 00", k, {s1_rvalid[k], s2_rvalid[k]}); end
    end
    step();
    reset_n = 1;
    for (int i = 0; i < 30; i++) step();
    for (int k = 0; k < 2; k++) begin
      checks++; if (busy[k] !== 1'b0) begin errors++; $display("FAIL abort_refill_done dut%0d: got %b expected 0", k, busy[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_init_fill();
    test_byteenable();
    test_forward();
    test_back_to_back();
    test_collision();
    test_clear_restart();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
